// File: rtl/count_stream_checker.sv
// Receive-side checker for a free-running modulo-2^WIDTH count stream.
// Tracks lock on consecutive +1 increments and reports errors, stalls and the last sample.
module count_stream_checker #(
  parameter int WIDTH    = 8,
  parameter int RELOCK_N = 2,
  parameter int ERR_W    = 8,
  parameter int TIMEOUT  = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  input  logic             clear_in,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic             stall,
  output logic [WIDTH-1:0] last_value
);

  localparam int GW = (RELOCK_N < 2) ? 1 : $clog2(RELOCK_N + 1);
  localparam int IW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [GW-1:0] RELOCK_V  = GW'(RELOCK_N);
  localparam logic [IW-1:0] TIMEOUT_V = IW'(TIMEOUT);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] ref_reg, ref_next;
  logic [GW-1:0]    good_cnt_reg, good_cnt_next;
  logic [IW-1:0]    idle_cnt_reg, idle_cnt_next;
  logic             locked_reg, locked_next;
  logic             err_pulse_reg, err_pulse_next;
  logic [ERR_W-1:0] err_count_reg, err_count_next;
  logic             stall_reg, stall_next;
  logic [WIDTH-1:0] last_value_reg, last_value_next;

  logic [WIDTH-1:0] ref_inc;
  logic [GW-1:0]    good_inc;
  logic [IW-1:0]    idle_inc;
  logic             match;

  assign ref_inc  = ref_reg + 1'b1;
  assign good_inc = good_cnt_reg + 1'b1;
  assign idle_inc = idle_cnt_reg + 1'b1;
  assign match    = (data_in == ref_inc);

  always_comb begin
    state_next      = state_reg;
    ref_next        = ref_reg;
    good_cnt_next   = good_cnt_reg;
    idle_cnt_next   = idle_cnt_reg;
    locked_next     = locked_reg;
    err_pulse_next  = 1'b0;
    err_count_next  = err_count_reg;
    stall_next      = stall_reg;
    last_value_next = last_value_reg;

    if (clear_in) begin
      // Clear wins over a same-cycle sample, which is dropped entirely.
      state_next     = SEARCH;
      locked_next    = 1'b0;
      err_count_next = '0;
      stall_next     = 1'b0;
      good_cnt_next  = '0;
      idle_cnt_next  = '0;
    end else begin
      case (state_reg)
        SEARCH: begin
          if (valid_in) begin
            ref_next        = data_in;
            last_value_next = data_in;
            good_cnt_next   = '0;
            state_next      = TRACK;
          end
        end
        TRACK: begin
          if (valid_in) begin
            ref_next        = data_in;
            last_value_next = data_in;
            if (match) begin
              good_cnt_next = good_inc;
              if (good_inc == RELOCK_V) begin
                state_next    = LOCKED;
                locked_next   = 1'b1;
                idle_cnt_next = '0;
              end
            end else begin
              good_cnt_next = '0;
            end
          end
        end
        LOCKED: begin
          if (valid_in) begin
            ref_next        = data_in;
            last_value_next = data_in;
            idle_cnt_next   = '0;
            if (!match) begin
              err_pulse_next = 1'b1;
              if (err_count_reg != {ERR_W{1'b1}})
                err_count_next = err_count_reg + 1'b1;
              locked_next   = 1'b0;
              good_cnt_next = '0;
              state_next    = TRACK;
            end
          end else if (TIMEOUT != 0) begin
            // Fires on the edge that closes the TIMEOUT-th consecutive idle cycle.
            if (idle_inc == TIMEOUT_V) begin
              state_next    = SEARCH;
              locked_next   = 1'b0;
              stall_next    = 1'b1;
              idle_cnt_next = '0;
            end else begin
              idle_cnt_next = idle_inc;
            end
          end
        end
        default: begin
          state_next  = SEARCH;
          locked_next = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= SEARCH;
      ref_reg        <= '0;
      good_cnt_reg   <= '0;
      idle_cnt_reg   <= '0;
      locked_reg     <= 1'b0;
      err_pulse_reg  <= 1'b0;
      err_count_reg  <= '0;
      stall_reg      <= 1'b0;
      last_value_reg <= '0;
    end else begin
      state_reg      <= state_next;
      ref_reg        <= ref_next;
      good_cnt_reg   <= good_cnt_next;
      idle_cnt_reg   <= idle_cnt_next;
      locked_reg     <= locked_next;
      err_pulse_reg  <= err_pulse_next;
      err_count_reg  <= err_count_next;
      stall_reg      <= stall_next;
      last_value_reg <= last_value_next;
    end
  end

  assign locked     = locked_reg;
  assign err_pulse  = err_pulse_reg;
  assign err_count  = err_count_reg;
  assign stall      = stall_reg;
  assign last_value = last_value_reg;

endmodule

// File: tb/tb_count_stream_checker.sv
// Directed bench for count_stream_checker: vector table plus hand-written
// sequences for saturation, idle timeout, clear and mid-stream reset.
module tb_count_stream_checker;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       valid_in;
  logic       clear_in;
  logic       locked;
  logic       err_pulse;
  logic [7:0] err_count;
  logic       stall;
  logic [7:0] last_value;

  int n_cmp = 0;
  int n_err = 0;

  count_stream_checker dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .clear_in  (clear_in),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .stall     (stall),
    .last_value(last_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic       c;
    logic [7:0] d;
    logic       e_locked;
    logic       e_pulse;
    logic [7:0] e_count;
    logic       e_stall;
    logic [7:0] e_last;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic chk_all(input string tag, input logic el, input logic ep,
                         input logic [7:0] ec, input logic es, input logic [7:0] elv);
    chk({tag, ".locked"},     int'(locked),     int'(el));
    chk({tag, ".err_pulse"},  int'(err_pulse),  int'(ep));
    chk({tag, ".err_count"},  int'(err_count),  int'(ec));
    chk({tag, ".stall"},      int'(stall),      int'(es));
    chk({tag, ".last_value"}, int'(last_value), int'(elv));
  endtask

  // Drive inputs, let one rising edge pass, then settle before sampling.
  task automatic step(input logic v, input logic c, input logic [7:0] d);
    valid_in = v;
    clear_in = c;
    data_in  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 8'd0);
  endtask

  initial begin
    logic [7:0] r;
    int         exp_ec;

    rst = 1'b1; valid_in = 1'b0; clear_in = 1'b0; data_in = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 1'b0, 1'b0, 8'd0, 1'b0, 8'd0);
    $display("reset state checked");
    #3 rst = 1'b0;

    //          v     c     d       lock  pulse cnt   stall last
    vecs[0]  = '{1'b1, 1'b0, 8'd0,   1'b0, 1'b0, 8'd0, 1'b0, 8'd0};
    vecs[1]  = '{1'b1, 1'b0, 8'd1,   1'b0, 1'b0, 8'd0, 1'b0, 8'd1};
    vecs[2]  = '{1'b1, 1'b0, 8'd2,   1'b1, 1'b0, 8'd0, 1'b0, 8'd2};
    vecs[3]  = '{1'b1, 1'b0, 8'd3,   1'b1, 1'b0, 8'd0, 1'b0, 8'd3};
    vecs[4]  = '{1'b0, 1'b1, 8'd0,   1'b0, 1'b0, 8'd0, 1'b0, 8'd3};
    vecs[5]  = '{1'b1, 1'b0, 8'd252, 1'b0, 1'b0, 8'd0, 1'b0, 8'd252};
    vecs[6]  = '{1'b1, 1'b0, 8'd253, 1'b0, 1'b0, 8'd0, 1'b0, 8'd253};
    vecs[7]  = '{1'b1, 1'b0, 8'd254, 1'b1, 1'b0, 8'd0, 1'b0, 8'd254};
    vecs[8]  = '{1'b1, 1'b0, 8'd255, 1'b1, 1'b0, 8'd0, 1'b0, 8'd255};
    vecs[9]  = '{1'b1, 1'b0, 8'd0,   1'b1, 1'b0, 8'd0, 1'b0, 8'd0};
    vecs[10] = '{1'b1, 1'b0, 8'd1,   1'b1, 1'b0, 8'd0, 1'b0, 8'd1};
    vecs[11] = '{1'b1, 1'b0, 8'd2,   1'b1, 1'b0, 8'd0, 1'b0, 8'd2};
    vecs[12] = '{1'b1, 1'b0, 8'd3,   1'b1, 1'b0, 8'd0, 1'b0, 8'd3};
    vecs[13] = '{1'b1, 1'b0, 8'd4,   1'b1, 1'b0, 8'd0, 1'b0, 8'd4};
    vecs[14] = '{1'b1, 1'b0, 8'd5,   1'b1, 1'b0, 8'd0, 1'b0, 8'd5};
    vecs[15] = '{1'b1, 1'b0, 8'd9,   1'b0, 1'b1, 8'd1, 1'b0, 8'd9};
    vecs[16] = '{1'b0, 1'b0, 8'd0,   1'b0, 1'b0, 8'd1, 1'b0, 8'd9};
    vecs[17] = '{1'b1, 1'b0, 8'd10,  1'b0, 1'b0, 8'd1, 1'b0, 8'd10};
    vecs[18] = '{1'b1, 1'b0, 8'd11,  1'b1, 1'b0, 8'd1, 1'b0, 8'd11};
    vecs[19] = '{1'b1, 1'b1, 8'd7,   1'b0, 1'b0, 8'd0, 1'b0, 8'd11};

    for (int i = 0; i < 20; i++) begin
      step(vecs[i].v, vecs[i].c, vecs[i].d);
      chk_all($sformatf("vec%0d", i), vecs[i].e_locked, vecs[i].e_pulse,
              vecs[i].e_count, vecs[i].e_stall, vecs[i].e_last);
      $display("vec%0d v=%0d c=%0d d=%0d -> locked=%0d pulse=%0d cnt=%0d stall=%0d last=%0d",
               i, vecs[i].v, vecs[i].c, vecs[i].d, locked, err_pulse, err_count, stall, last_value);
    end

    // Saturation: 260 relock-then-mismatch loops starting from SEARCH.
    r = 8'd100;
    step(1'b1, 1'b0, r);
    for (int i = 0; i < 260; i++) begin
      step(1'b1, 1'b0, r + 8'd1);
      step(1'b1, 1'b0, r + 8'd2);
      chk($sformatf("sat%0d.locked", i), int'(locked), 1);
      chk($sformatf("sat%0d.quiet", i), int'(err_pulse), 0);
      r = r + 8'd7;
      step(1'b1, 1'b0, r);
      exp_ec = (i + 1 > 255) ? 255 : i + 1;
      chk($sformatf("sat%0d.err_pulse", i), int'(err_pulse), 1);
      chk($sformatf("sat%0d.err_count", i), int'(err_count), exp_ec);
      chk($sformatf("sat%0d.unlocked", i), int'(locked), 0);
      $display("sat%0d mismatch d=%0d -> pulse=%0d cnt=%0d", i, r, err_pulse, err_count);
    end

    // Idle timeout: 255 idle cycles keep lock, 256 declare the stall.
    step(1'b1, 1'b0, r + 8'd1);
    step(1'b1, 1'b0, r + 8'd2);
    chk("to.relock", int'(locked), 1);
    idle(255);
    chk("to255.locked", int'(locked), 1);
    chk("to255.stall", int'(stall), 0);
    step(1'b1, 1'b0, r + 8'd3);
    chk_all("to255.sample", 1'b1, 1'b0, 8'd255, 1'b0, r + 8'd3);
    $display("idle 255 then sample -> locked=%0d stall=%0d", locked, stall);
    idle(255);
    chk("to256.pre", int'(locked), 1);
    idle(1);
    chk_all("to256", 1'b0, 1'b0, 8'd255, 1'b1, r + 8'd3);
    $display("idle 256 -> locked=%0d stall=%0d", locked, stall);
    // In SEARCH the next sample only seeds ref, so lock needs two more matches.
    step(1'b1, 1'b0, r + 8'd4);
    chk("srch.s1", int'(locked), 0);
    step(1'b1, 1'b0, r + 8'd5);
    chk("srch.s2", int'(locked), 0);
    step(1'b1, 1'b0, r + 8'd6);
    chk_all("srch.s3", 1'b1, 1'b0, 8'd255, 1'b1, r + 8'd6);
    $display("after stall relock -> locked=%0d stall=%0d", locked, stall);

    // Clear with a concurrent sample drops the sample and clears stall/count.
    step(1'b1, 1'b1, 8'd7);
    chk_all("clr", 1'b0, 1'b0, 8'd0, 1'b0, r + 8'd6);
    $display("clear+sample -> locked=%0d cnt=%0d stall=%0d last=%0d", locked, err_count, stall, last_value);

    // Mid-stream async reset clears outputs without waiting for an edge.
    step(1'b1, 1'b0, 8'd40);
    step(1'b1, 1'b0, 8'd41);
    step(1'b1, 1'b0, 8'd42);
    chk("pre_rst.locked", int'(locked), 1);
    #2 rst = 1'b1;
    #1;
    chk_all("async_rst", 1'b0, 1'b0, 8'd0, 1'b0, 8'd0);
    $display("async reset mid-cycle -> locked=%0d last=%0d", locked, last_value);
    valid_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b0, 8'd43);
    chk_all("post_rst", 1'b0, 1'b0, 8'd0, 1'b0, 8'd43);
    $display("post reset sample -> locked=%0d last=%0d", locked, last_value);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
